hazard_forward_unit: RTL and testbench
======================================

HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 Parameter REG_W, default 5: register-address width.
REQ-002 Parameter NUM_SRC, default 2: source operands per instruction (channels).
REQ-003 Parameter MEM_WAIT, default 0, range 0..7: extra cycles a load occupies MEM.
REQ-004 Parameter CNT_W, default 16: stall-counter width.
REQ-005 Clock and reset SHALL be: one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  asynchronous active-low reset.
REQ-008 id_ex_rs  in  NUM_SRC*REG_W  sources of the EX instruction; source i occupies bits [i*REG_W +: REG_W].
REQ-009 if_id_rs  in  NUM_SRC*REG_W  sources of the ID instruction; same packing as id_ex_rs.
REQ-010 if_id_rs_use  in  NUM_SRC  per-source "operand actually read" mask for ID.
REQ-011 id_ex_valid, id_ex_mem_read  in  1 each  EX slot valid / EX instruction is a load.
REQ-012 id_ex_rd  in  REG_W  destination of the EX instruction.
REQ-013 ex_mem_valid, ex_mem_reg_write, ex_mem_mem_read  in  1 each  MEM-slot qualifiers.
REQ-014 ex_mem_rd  in  REG_W  destination of the MEM instruction.
REQ-015 mem_wb_reg_write  in  1; mem_wb_rd  in  REG_W  WB-slot qualifier and destination.
REQ-016 stall_cnt_clr  in  1  synchronous clear of stall_cnt.
REQ-017 fwd_sel  out  NUM_SRC*2  per-source operand mux select; same packing as id_ex_rs, 2 bits per source.
REQ-018 stall_if, stall_id, bubble_ex  out  1 each  hold PC / hold IF-ID / insert NOP into ID-EX.
REQ-019 freeze  out  1  hold every pipeline register.
REQ-020 stall_cnt  out  CNT_W  saturating count of stalled cycles.

Function
REQ-021 fwd_sel[i] SHALL be combinational: 10 if ex_mem_reg_write, ex_mem_rd!=0, ex_mem_rd==rs_i and !ex_mem_mem_read; else 01 if mem_wb_reg_write, mem_wb_rd!=0, mem_wb_rd==rs_i; else 00.
REQ-022 EX/MEM match SHALL take priority over MEM/WB match for the same source.
REQ-023 lu (load-use) SHALL be id_ex_valid & id_ex_mem_read & id_ex_rd!=0 & OR over i of (if_id_rs_use[i] & if_id_rs_i==id_ex_rd).
REQ-024 FSM states SHALL be RUN and WAIT, with a 3-bit down-counter cnt.
REQ-025 In RUN: trig = ex_mem_valid & ex_mem_mem_read & (MEM_WAIT!=0); freeze = trig; on trig, next state WAIT and cnt <= MEM_WAIT-1.
REQ-026 In WAIT: freeze = (cnt!=0); if cnt!=0, cnt decrements; if cnt==0, next state RUN and trig is ignored that cycle.
REQ-027 Each load SHALL therefore be frozen for exactly MEM_WAIT consecutive cycles.
REQ-028 Back-to-back loads SHALL each retrigger in RUN.
REQ-029 With MEM_WAIT=0 the FSM SHALL remain in RUN and freeze SHALL stay 0.
REQ-030 stall_if = stall_id = bubble_ex = lu & !freeze; freeze SHALL dominate (no bubble while frozen).
REQ-031 stall_cnt SHALL increment by 1 per cycle with (freeze | lu) and saturate at all-ones.
REQ-032 stall_cnt_clr SHALL take priority over increment and SHALL load 0.

Reset
REQ-033 rst_n low SHALL force state RUN, cnt 0 and stall_cnt 0 immediately, independent of clk, including mid-WAIT.
REQ-034 During and after reset, combinational outputs SHALL reflect inputs with state RUN.

Structure
REQ-035 A shared package hazard_pkg SHALL hold FWD_RF=00, FWD_MEM_WB=01, FWD_EX_MEM=10 and the RUN/WAIT state encoding.
REQ-036 A sub-module fwd_select (one source comparator, REQ-021) SHALL be instantiated NUM_SRC times via generate.

Verification (REG_W=5, NUM_SRC=2, MEM_WAIT=2, CNT_W=4)
REQ-037 ex_mem rd=3 wr=1, mem_wb rd=3 wr=1, id_ex rs0=3 -> fwd_sel[1:0]=10; with ex_mem_mem_read=1 -> 01.
REQ-038 id_ex load rd=5, if_id rs1=5 use=10 -> stall_if=stall_id=bubble_ex=1; same case with use=00 -> all 0; rd=0 -> all 0.
REQ-039 Single load enters MEM -> freeze=1 for exactly 2 cycles, then 0 with state RUN; back-to-back loads -> two 2-cycle freezes.
REQ-040 lu asserted during freeze -> bubble_ex=0 while freeze=1, then 1 in the first unfrozen cycle.
REQ-041 rst_n pulsed low mid-WAIT -> freeze drops asynchronously; stall_cnt=0; 20 stall cycles -> stall_cnt=15 (saturated); clr -> 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// hazard_pkg: operand-mux select codes and freeze-FSM state encoding shared by the hazard unit
package hazard_pkg;
    localparam logic [1:0] FWD_RF     = 2'b00;
    localparam logic [1:0] FWD_MEM_WB = 2'b01;
    localparam logic [1:0] FWD_EX_MEM = 2'b10;
    typedef enum logic {RUN = 1'b0, WAIT = 1'b1} state_t;
endpackage

// File: rtl/fwd_select.sv
// fwd_select: forwarding-path select for one source operand
//   rs                 source register of the EX instruction
//   ex_mem_*           MEM-slot write qualifier, load flag, destination
//   mem_wb_*           WB-slot write qualifier, destination
//   sel                FWD_EX_MEM / FWD_MEM_WB / FWD_RF
module fwd_select import hazard_pkg::*; #(
    parameter int REG_W = 5
) (
    input  logic [REG_W-1:0] rs,
    input  logic             ex_mem_reg_write,
    input  logic             ex_mem_mem_read,
    input  logic [REG_W-1:0] ex_mem_rd,
    input  logic             mem_wb_reg_write,
    input  logic [REG_W-1:0] mem_wb_rd,
    output logic [1:0]       sel
);
    logic hit_ex_mem;
    logic hit_mem_wb;
    // a load in MEM has no data yet, so it cannot feed EX; the nearer producer wins
    assign hit_ex_mem = ex_mem_reg_write && ex_mem_rd != '0 && ex_mem_rd == rs && !ex_mem_mem_read;
    assign hit_mem_wb = mem_wb_reg_write && mem_wb_rd != '0 && mem_wb_rd == rs;
    assign sel = hit_ex_mem ? FWD_EX_MEM : hit_mem_wb ? FWD_MEM_WB : FWD_RF;
endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: operand forwarding, load-use stall and multi-cycle load freeze
//   id_ex_rs / if_id_rs    packed sources of EX / ID instruction, REG_W bits each
//   if_id_rs_use           per-source "actually read" mask for ID
//   id_ex_*, ex_mem_*, mem_wb_*  slot qualifiers and destinations
//   stall_cnt_clr          synchronous clear of stall_cnt
//   fwd_sel                2-bit operand mux select per source
//   stall_if/stall_id/bubble_ex  load-use stall controls
//   freeze                 hold every pipeline register while a load occupies MEM
//   stall_cnt              saturating count of stalled cycles
module hazard_forward_unit import hazard_pkg::*; #(
    parameter int REG_W    = 5,
    parameter int NUM_SRC  = 2,
    parameter int MEM_WAIT = 0,
    parameter int CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_SRC*REG_W-1:0] id_ex_rs,
    input  logic [NUM_SRC*REG_W-1:0] if_id_rs,
    input  logic [NUM_SRC-1:0]       if_id_rs_use,
    input  logic                     id_ex_valid,
    input  logic                     id_ex_mem_read,
    input  logic [REG_W-1:0]         id_ex_rd,
    input  logic                     ex_mem_valid,
    input  logic                     ex_mem_reg_write,
    input  logic                     ex_mem_mem_read,
    input  logic [REG_W-1:0]         ex_mem_rd,
    input  logic                     mem_wb_reg_write,
    input  logic [REG_W-1:0]         mem_wb_rd,
    input  logic                     stall_cnt_clr,
    output logic [NUM_SRC*2-1:0]     fwd_sel,
    output logic                     stall_if,
    output logic                     stall_id,
    output logic                     bubble_ex,
    output logic                     freeze,
    output logic [CNT_W-1:0]         stall_cnt
);
    localparam logic       HAS_WAIT = MEM_WAIT != 0;
    localparam logic [2:0] CNT_INIT = 3'(MEM_WAIT - 1);
    state_t     state;
    logic [2:0] cnt;
    logic       trig;
    logic       lu;
    logic       lu_hit;
    genvar g;
    generate
        for (g = 0; g < NUM_SRC; g++) begin : g_src
            fwd_select #(.REG_W(REG_W)) u_sel (
                .rs               (id_ex_rs[g*REG_W +: REG_W]),
                .ex_mem_reg_write (ex_mem_reg_write),
                .ex_mem_mem_read  (ex_mem_mem_read),
                .ex_mem_rd        (ex_mem_rd),
                .mem_wb_reg_write (mem_wb_reg_write),
                .mem_wb_rd        (mem_wb_rd),
                .sel              (fwd_sel[g*2 +: 2])
            );
        end
    endgenerate
    always_comb begin
        lu_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++)
            lu_hit = lu_hit | (if_id_rs_use[i] && if_id_rs[i*REG_W +: REG_W] == id_ex_rd);
    end
    assign lu        = id_ex_valid && id_ex_mem_read && id_ex_rd != '0 && lu_hit;
    assign trig      = ex_mem_valid && ex_mem_mem_read && HAS_WAIT;
    // the cycle a WAIT run ends the held load is still in MEM, so trig is ignored there
    assign freeze    = state == RUN ? trig : cnt != '0;
    assign stall_if  = lu && !freeze;
    assign stall_id  = stall_if;
    assign bubble_ex = stall_if;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
            cnt   <= '0;
        end else if (state == RUN) begin
            if (trig) begin
                state <= WAIT;
                cnt   <= CNT_INIT;
            end
        end else if (cnt != '0) begin
            cnt <= cnt - 3'd1;
        end else begin
            state <= RUN;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            stall_cnt <= '0;
        else if (stall_cnt_clr)
            stall_cnt <= '0;
        else if ((freeze || lu) && stall_cnt != '1)
            stall_cnt <= stall_cnt + 1'b1;
    end
endmodule

// File: tb/tb_hazard_forward_unit.sv
// tb_hazard_forward_unit: directed checks of forwarding, load-use stall, freeze FSM and stall counter
module tb_hazard_forward_unit;
    logic        clk = 1'b0;
    logic        rst_n;
    logic [9:0]  id_ex_rs, if_id_rs;
    logic [1:0]  if_id_rs_use;
    logic        id_ex_valid, id_ex_mem_read;
    logic [4:0]  id_ex_rd;
    logic        ex_mem_valid, ex_mem_reg_write, ex_mem_mem_read;
    logic [4:0]  ex_mem_rd;
    logic        mem_wb_reg_write;
    logic [4:0]  mem_wb_rd;
    logic        stall_cnt_clr;
    logic [3:0]  fwd_sel;
    logic        stall_if, stall_id, bubble_ex, freeze;
    logic [3:0]  stall_cnt;
    int checks = 0;
    int errors = 0;

    hazard_forward_unit #(.REG_W(5), .NUM_SRC(2), .MEM_WAIT(2), .CNT_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_ex_rs(id_ex_rs), .if_id_rs(if_id_rs), .if_id_rs_use(if_id_rs_use),
        .id_ex_valid(id_ex_valid), .id_ex_mem_read(id_ex_mem_read), .id_ex_rd(id_ex_rd),
        .ex_mem_valid(ex_mem_valid), .ex_mem_reg_write(ex_mem_reg_write),
        .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_rd(ex_mem_rd),
        .mem_wb_reg_write(mem_wb_reg_write), .mem_wb_rd(mem_wb_rd),
        .stall_cnt_clr(stall_cnt_clr),
        .fwd_sel(fwd_sel), .stall_if(stall_if), .stall_id(stall_id),
        .bubble_ex(bubble_ex), .freeze(freeze), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] ctl();
        return {stall_if, stall_id, bubble_ex, freeze};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        id_ex_rs = '0; if_id_rs = '0; if_id_rs_use = '0;
        id_ex_valid = 0; id_ex_mem_read = 0; id_ex_rd = '0;
        ex_mem_valid = 0; ex_mem_reg_write = 0; ex_mem_mem_read = 0; ex_mem_rd = '0;
        mem_wb_reg_write = 0; mem_wb_rd = '0; stall_cnt_clr = 0;
        #12;
        check("rst_cnt", stall_cnt, 4'd0);
        check("rst_ctl", ctl(), 4'b0000);
        check("rst_fwd", fwd_sel, 4'b0000);
        tick();
        rst_n = 1'b1;
        // forwarding
        ex_mem_rd = 5'd3; ex_mem_reg_write = 1; mem_wb_rd = 5'd3; mem_wb_reg_write = 1;
        id_ex_rs = {5'd0, 5'd3};
        #1 check("fwd_exmem", fwd_sel, 4'b0010);
        ex_mem_mem_read = 1;
        #1 check("fwd_load_in_mem", fwd_sel, 4'b0001);
        ex_mem_mem_read = 0; ex_mem_reg_write = 0;
        #1 check("fwd_memwb", fwd_sel, 4'b0001);
        ex_mem_reg_write = 1; ex_mem_rd = 5'd7; id_ex_rs = {5'd7, 5'd3};
        #1 check("fwd_both_src", fwd_sel, 4'b1001);
        ex_mem_rd = 5'd0; mem_wb_rd = 5'd0; id_ex_rs = {5'd0, 5'd0};
        #1 check("fwd_r0", fwd_sel, 4'b0000);
        ex_mem_reg_write = 0; mem_wb_reg_write = 0;
        // load-use
        id_ex_valid = 1; id_ex_mem_read = 1; id_ex_rd = 5'd5;
        if_id_rs = {5'd5, 5'd2}; if_id_rs_use = 2'b10;
        #1 check("lu_hit", ctl(), 4'b1110);
        if_id_rs_use = 2'b00;
        #1 check("lu_unused", ctl(), 4'b0000);
        if_id_rs_use = 2'b10; id_ex_rd = 5'd0; if_id_rs = {5'd0, 5'd2};
        #1 check("lu_rd0", ctl(), 4'b0000);
        id_ex_rd = 5'd5; if_id_rs = {5'd5, 5'd2}; id_ex_valid = 0;
        #1 check("lu_invalid", ctl(), 4'b0000);
        id_ex_mem_read = 0;
        // single load freeze
        tick();
        ex_mem_valid = 1; ex_mem_mem_read = 1;
        #1 check("ld1_c0", freeze, 1'b1);
        tick(); check("ld1_c1", freeze, 1'b1);
        tick(); check("ld1_c2", freeze, 1'b0);
        ex_mem_valid = 0;
        tick(); check("ld1_run", freeze, 1'b0);
        // back-to-back loads
        ex_mem_valid = 1;
        #1 check("b2b_a0", freeze, 1'b1);
        tick(); check("b2b_a1", freeze, 1'b1);
        tick(); check("b2b_a2", freeze, 1'b0);
        tick(); check("b2b_b0", freeze, 1'b1);
        tick(); check("b2b_b1", freeze, 1'b1);
        tick(); check("b2b_b2", freeze, 1'b0);
        ex_mem_valid = 0;
        tick(); check("b2b_run", freeze, 1'b0);
        // load-use while frozen
        ex_mem_valid = 1;
        id_ex_valid = 1; id_ex_mem_read = 1;
        #1 check("lufz_c0", ctl(), 4'b0001);
        tick(); check("lufz_c1", ctl(), 4'b0001);
        tick(); check("lufz_c2", ctl(), 4'b1110);
        ex_mem_valid = 0; id_ex_valid = 0; id_ex_mem_read = 0;
        tick();
        // async reset mid-WAIT
        ex_mem_valid = 1;
        tick();
        ex_mem_valid = 0;
        #1 check("wait_frozen", freeze, 1'b1);
        rst_n = 0;
        #1 check("async_rst_freeze", freeze, 1'b0);
        check("async_rst_cnt", stall_cnt, 4'd0);
        tick();
        rst_n = 1;
        tick(); check("post_rst_freeze", freeze, 1'b0);
        // stall counter
        stall_cnt_clr = 1;
        tick();
        stall_cnt_clr = 0;
        check("cnt_clr0", stall_cnt, 4'd0);
        id_ex_valid = 1; id_ex_mem_read = 1;
        repeat (3) tick();
        check("cnt_3", stall_cnt, 4'd3);
        repeat (17) tick();
        check("cnt_sat", stall_cnt, 4'd15);
        stall_cnt_clr = 1;
        tick();
        check("cnt_clr_prio", stall_cnt, 4'd0);
        stall_cnt_clr = 0;
        tick();
        check("cnt_after_clr", stall_cnt, 4'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
